// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: four-requester round-robin arbiter with a one-hot grant,
// grant hold while the owner keeps requesting, and bounded tenure under
// contention (forced rotation after MAX_HOLD cycles).
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8   // legal range 2..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    // Last tenure count before a contended owner must give way.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0] state_q,     state_d;
    logic [3:0] grant_q,     grant_d;
    logic [1:0] grant_idx_q, grant_idx_d;
    logic [1:0] last_idx_q,  last_idx_d;
    logic [7:0] hold_cnt_q,  hold_cnt_d;

    logic [3:0] search_mask;
    logic [1:0] cand_idx;
    logic [1:0] win_idx;
    logic       win_found;

    // Same mapping as the team's 2-to-4 decoder.
    function automatic logic [3:0] decode_2to4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Round-robin search from last_idx+1; the current owner is masked out
    // while a grant is held, so it can only win through the IDLE path.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        search_mask = (state_q == ST_OWN) ? (req & ~decode_2to4(grant_idx_q)) : req;
        cand_idx    = last_idx_q;
        win_idx     = last_idx_q;
        win_found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand_idx = last_idx_q + 2'(k);
            if (!win_found && search_mask[cand_idx]) begin
                win_idx   = cand_idx;
                win_found = 1'b1;
            end
        end
    end

    // Next-state logic: IDLE/OWN transitions, handover and tenure counting.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        hold_cnt_d  = hold_cnt_q;

        if (state_q == ST_IDLE) begin
            if (win_found) begin
                state_d     = ST_OWN;
                grant_idx_d = win_idx;
                last_idx_d  = win_idx;
                hold_cnt_d  = 8'd0;
            end
        end else begin
            if (!req[grant_idx_q]) begin
                // Release: hand straight over (no idle gap) or go idle.
                if (win_found) begin
                    grant_idx_d = win_idx;
                    last_idx_d  = win_idx;
                end else begin
                    state_d = ST_IDLE;
                end
                hold_cnt_d = 8'd0;
            end else if (hold_cnt_q == HOLD_LAST && win_found) begin
                // Tenure expired with someone waiting: forced rotation.
                grant_idx_d = win_idx;
                last_idx_d  = win_idx;
                hold_cnt_d  = 8'd0;
            end else if (hold_cnt_q != HOLD_LAST) begin
                // Saturate instead of wrapping when nobody else is waiting.
                hold_cnt_d = hold_cnt_q + 8'd1;
            end
        end

        grant_d = (state_d == ST_OWN) ? decode_2to4(grant_idx_d) : 4'b0000;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= 4'b0000;
            grant_idx_q <= 2'b00;
            last_idx_q  <= 2'b11;   // requester 0 first after reset
            hold_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = (state_q == ST_OWN);

endmodule
